sipo_frame_deserializer: RTL and testbench

Receives the LSB-first serial bitstream produced by the team's parallel-in/serial-out shift register and reassembles it into N-bit parallel words. It sits directly downstream of the PISO stage, with `serial_in` driven by the PISO `serial_out`. Output words are held in a one-word output register behind a valid/ready handshake, so reception continues while the consumer stalls. Framing errors and overruns are flagged.

---
 rtl/sipo_pkg.sv | 13 +
 rtl/sipo_out_holder.sv | 49 ++++
 rtl/sipo_frame_deserializer.sv | 93 +++++++++
 tb/tb_sipo_frame_deserializer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO frame deserializer family.
package sipo_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_out_holder.sv
// One-word valid/ready output register; a word arriving
// while the held word is stalled is dropped and flagged.
module sipo_out_holder
  import sipo_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [N-1:0] wr_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] parallel_out,
  output logic         overrun
);

  logic         valid_q;
  logic [N-1:0] data_q;
  logic         ovr_q;
  logic         can_wr;

  assign can_wr = !valid_q || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (wr_en) begin
        if (can_wr) begin
          data_q  <= wr_data;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid    = valid_q;
  assign parallel_out = data_q;
  assign overrun      = ovr_q;

endmodule

// File: rtl/sipo_frame_deserializer.sv
// LSB-first serial-to-parallel deserializer with framing
// resync and a one-word valid/ready output stage.
module sipo_frame_deserializer
  import sipo_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         bit_valid,
  input  logic         frame_start,
  input  logic         out_ready,
  output logic [N-1:0] parallel_out,
  output logic         out_valid,
  output logic         busy,
  output logic         frame_error,
  output logic         overrun
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  sr_q;
  logic          fe_q;

  logic [N-1:0]  shifted;
  logic          last_bit;
  logic          wr_en;
  logic          sr_unused;

  assign shifted   = {serial_in, sr_q[N-1:1]};
  assign sr_unused = sr_q[0];
  assign last_bit  = (cnt_q == CNT_LAST);

  // A frame_start on the completing bit resyncs instead.
  assign wr_en = (state_q == SHIFT) && bit_valid
              && !frame_start && last_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      fe_q    <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bit_valid && frame_start) begin
            sr_q    <= shifted;
            cnt_q   <= CNT_ONE;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            sr_q <= shifted;
            if (frame_start) begin
              cnt_q <= CNT_ONE;
              fe_q  <= (cnt_q != '0);
            end else if (last_bit) begin
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sipo_out_holder #(
    .N(N)
  ) u_out (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (shifted),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .parallel_out (parallel_out),
    .overrun      (overrun)
  );

  assign busy        = (state_q == SHIFT);
  assign frame_error = fe_q;

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// Directed bench for sipo_frame_deserializer, N=4.
module tb_sipo_frame_deserializer;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic         serial_in;
  logic         bit_valid;
  logic         frame_start;
  logic         out_ready;
  logic [N-1:0] parallel_out;
  logic         out_valid;
  logic         busy;
  logic         frame_error;
  logic         overrun;

  int checks;
  int failures;

  sipo_frame_deserializer #(
    .N(N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic bv, input logic fs,
                     input logic si, input logic rdy);
    bit_valid   = bv;
    frame_start = fs;
    serial_in   = si;
    out_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, "_po"},   32'(parallel_out), 32'h0);
    chk({tag, "_ov"},   32'(out_valid),    32'h0);
    chk({tag, "_busy"}, 32'(busy),         32'h0);
    chk({tag, "_fe"},   32'(frame_error),  32'h0);
    chk({tag, "_ovr"},  32'(overrun),      32'h0);
  endtask

  logic [7:0] stream;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_all0("rst");
    reset = 1'b0;

    // basic word 1,0,1,1 -> D
    cyc(1, 1, 1, 1);
    chk("t1_busy", 32'(busy), 32'h1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 1);
    chk("t1_novalid", 32'(out_valid), 32'h0);
    cyc(1, 0, 1, 1);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(parallel_out), 32'hD);
    cyc(0, 0, 0, 1);
    chk("t1_1cyc", 32'(out_valid), 32'h0);

    // back-to-back stream
    stream = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      cyc(1, i == 0, stream[i], 1);
      chk("t2_fe", 32'(frame_error), 32'h0);
      chk("t2_ovr", 32'(overrun), 32'h0);
      if (i == 3) begin
        chk("t2_w0v", 32'(out_valid), 32'h1);
        chk("t2_w0", 32'(parallel_out), 32'hD);
      end
      if (i == 7) begin
        chk("t2_w1v", 32'(out_valid), 32'h1);
        chk("t2_w1", 32'(parallel_out), 32'h4);
      end
    end
    cyc(0, 0, 0, 1);

    // overrun with stalled consumer
    for (int i = 0; i < 8; i++) begin
      cyc(1, i == 0, stream[i], 0);
      if (i == 6)
        chk("t3_noovr", 32'(overrun), 32'h0);
    end
    chk("t3_ovr", 32'(overrun), 32'h1);
    chk("t3_keep", 32'(parallel_out), 32'hD);
    chk("t3_v", 32'(out_valid), 32'h1);
    cyc(0, 0, 0, 0);
    chk("t3_ovr1", 32'(overrun), 32'h0);
    chk("t3_stable", 32'(parallel_out), 32'hD);
    cyc(0, 0, 0, 1);
    chk("t3_clr", 32'(out_valid), 32'h0);

    // resync after 2 bits, then 0,1,1,1 -> E
    cyc(1, 1, 1, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 1, 0, 1);
    chk("t4_fe", 32'(frame_error), 32'h1);
    cyc(1, 0, 1, 1);
    chk("t4_fe1", 32'(frame_error), 32'h0);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 1);
    chk("t4_v", 32'(out_valid), 32'h1);
    chk("t4_data", 32'(parallel_out), 32'hE);
    cyc(0, 0, 0, 1);

    // resync on completing bit: no word, then 1,1,1,0 -> 7
    cyc(1, 1, 1, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 1);
    cyc(1, 1, 1, 1);
    chk("t5_fe", 32'(frame_error), 32'h1);
    chk("t5_nov", 32'(out_valid), 32'h0);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 0, 1);
    chk("t5_v", 32'(out_valid), 32'h1);
    chk("t5_data", 32'(parallel_out), 32'h7);
    cyc(0, 0, 0, 1);

    // gaps with serial_in toggling
    stream = 8'b0000_1101;
    for (int i = 0; i < 4; i++) begin
      cyc(1, i == 0, stream[i], 1);
      if (i < 3) begin
        cyc(0, 1, ~stream[i], 1);
        cyc(0, 0, stream[i], 1);
        chk("t6_nov", 32'(out_valid), 32'h0);
      end
    end
    chk("t6_v", 32'(out_valid), 32'h1);
    chk("t6_data", 32'(parallel_out), 32'hD);
    cyc(0, 0, 0, 1);

    // reset mid-word with a held word
    for (int i = 0; i < 4; i++)
      cyc(1, i == 0, stream[i], 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    chk("t7_held", 32'(parallel_out), 32'hD);
    reset = 1'b1;
    #1;
    chk_all0("t7_rst");
    cyc(0, 0, 0, 1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      cyc(1, 0, stream[i], 1);
    chk("t7_nofs_v", 32'(out_valid), 32'h0);
    chk("t7_nofs_b", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++)
      cyc(1, i == 0, stream[i], 1);
    chk("t7_v", 32'(out_valid), 32'h1);
    chk("t7_data", 32'(parallel_out), 32'hD);
    cyc(0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
